// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module   : multdiv_pkg
// Brief    : Shared encodings and helpers for the multi-cycle mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int ITER = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Unsigned magnitude; INT_MIN maps to 0x80000000, which still fits.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multdiv_step.sv
// ============================================================================
// Module   : multdiv_step
// Brief    : One combinational iteration: Booth radix-2 step or non-restoring
//            division step on a 33-bit partial accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_step (
    input  logic        mode,
    input  logic [32:0] acc,
    input  logic [31:0] q,
    input  logic        q_m1,
    input  logic [31:0] operand,
    output logic [32:0] acc_next,
    output logic [31:0] q_next,
    output logic        q_m1_next
);
    import multdiv_pkg::*;

    logic [32:0] w_sum;
    logic [32:0] w_shifted;

    always_comb begin
        w_sum     = acc;
        w_shifted = {acc[31:0], q[31]};
        acc_next  = acc;
        q_next    = q;
        q_m1_next = 1'b0;
        if (mode == OP_MUL) begin
            case ({q[0], q_m1})
                2'b01:   w_sum = acc + {operand[31], operand};
                2'b10:   w_sum = acc - {operand[31], operand};
                default: w_sum = acc;
            endcase
            acc_next  = {w_sum[32], w_sum[32:1]};
            q_next    = {w_sum[0], q[31:1]};
            q_m1_next = q[0];
        end else begin
            // Divisor magnitude is at most 2^31, so 33 signed bits never overflow.
            w_sum    = acc[32] ? (w_shifted + {1'b0, operand})
                               : (w_shifted - {1'b0, operand});
            acc_next = w_sum;
            q_next   = {q[30:0], ~w_sum[32]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// Module   : multdiv_unit
// Brief    : Multi-cycle signed 32-bit multiplier/divider with registered
//            result, exception flag and one-cycle ready strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_unit #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);
    import multdiv_pkg::*;

    logic [1:0]        r_state;
    logic [5:0]        r_cnt;
    logic              r_op;
    logic [32:0]       r_acc;
    logic [31:0]       r_q;
    logic              r_qm1;
    logic [31:0]       r_operand;
    logic              r_neg;
    logic              r_div_zero;
    logic              r_div_ovf;
    logic [DATA_W-1:0] r_result;
    logic              r_exc;
    logic              r_rdy;
    logic              r_busy;

    logic              w_start;
    logic              w_op;
    logic [32:0]       w_acc_next;
    logic [31:0]       w_q_next;
    logic              w_qm1_next;
    logic [63:0]       w_product;
    logic              w_mul_ovf;
    logic [31:0]       w_fix_result;
    logic              w_fix_exc;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_op    = ctrl_MULT ? OP_MUL : OP_DIV;

    multdiv_step u_step (
        .mode      (r_op),
        .acc       (r_acc),
        .q         (r_q),
        .q_m1      (r_qm1),
        .operand   (r_operand),
        .acc_next  (w_acc_next),
        .q_next    (w_q_next),
        .q_m1_next (w_qm1_next)
    );

    // Sign fix-up and exception detection, consumed in the DONE cycle.
    always_comb begin
        w_product    = {r_acc[31:0], r_q};
        w_mul_ovf    = !((&w_product[63:31]) || !(|w_product[63:31]));
        w_fix_result = r_q;
        w_fix_exc    = 1'b0;
        if (r_op == OP_MUL) begin
            w_fix_result = r_q;
            w_fix_exc    = w_mul_ovf;
        end else if (r_div_zero) begin
            w_fix_result = 32'd0;
            w_fix_exc    = 1'b1;
        end else if (r_div_ovf) begin
            w_fix_result = INT_MIN;
            w_fix_exc    = 1'b1;
        end else begin
            w_fix_result = r_neg ? (~r_q + 32'd1) : r_q;
            w_fix_exc    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 6'd0;
            r_op       <= OP_MUL;
            r_acc      <= 33'd0;
            r_q        <= 32'd0;
            r_qm1      <= 1'b0;
            r_operand  <= 32'd0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_result   <= '0;
            r_exc      <= 1'b0;
            r_rdy      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rdy  <= 1'b0;
            r_busy <= w_start || (r_state != ST_IDLE);
            // The DONE cycle always delivers, even if a new start arrives with it.
            if (r_state == ST_DONE) begin
                r_result <= w_fix_result;
                r_exc    <= w_fix_exc;
                r_rdy    <= 1'b1;
            end
            if (w_start) begin
                r_op       <= w_op;
                r_cnt      <= 6'd0;
                r_acc      <= 33'd0;
                r_qm1      <= 1'b0;
                r_neg      <= data_operandA[31] ^ data_operandB[31];
                r_div_zero <= (data_operandB == 32'd0);
                r_div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
                if (w_op == OP_MUL) begin
                    r_state   <= ST_MUL;
                    r_q       <= data_operandB;
                    r_operand <= data_operandA;
                end else begin
                    r_state   <= ST_DIV;
                    r_q       <= abs32(data_operandA);
                    r_operand <= abs32(data_operandB);
                end
            end else begin
                case (r_state)
                    ST_MUL, ST_DIV: begin
                        r_acc <= w_acc_next;
                        r_q   <= w_q_next;
                        r_qm1 <= w_qm1_next;
                        if (r_cnt == 6'(ITER - 1)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// Module   : tb_multdiv_unit
// Brief    : Directed and randomized scoreboard bench for multdiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

    localparam logic [31:0] C_INT_MIN = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];

    always #5 clock = ~clock;

    multdiv_unit #(.DATA_W(32), .ITER(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference built on native 64-bit signed arithmetic; returns {exception, result}.
    function automatic logic [32:0] model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        longint            la;
        longint            lb;
        logic signed [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [31:0] quo;
        logic               exc;
        sa  = a;
        sbv = b;
        if (is_mul) begin
            la  = sa;
            lb  = sbv;
            p   = la * lb;
            exc = !((p[63:31] == '0) || (p[63:31] == '1));
            return {exc, p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if ((a == C_INT_MIN) && (b == 32'hFFFF_FFFF)) return {1'b1, C_INT_MIN};
        quo = sa / sbv;
        return {1'b0, quo};
    endfunction

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", {32'd0, data_resultRDY}, 33'd0);
            end else begin
                check("result_exc", {data_exception, data_result}, exp_q.pop_front());
            end
        end
    end

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                            input logic [32:0] exp, input bit abort);
        if (abort) exp_q.delete();
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        exp_q.push_back(exp);
        @(posedge clock); #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Bounded wait; n is the cycle index relative to the start cycle.
    task automatic wait_rdy(input string tag, input int first_n, input int exp_n);
        int n;
        n = first_n;
        while (data_resultRDY !== 1'b1 && n < 80) begin
            @(posedge clock); #1;
            n++;
        end
        check(tag, 33'(n), 33'(exp_n));
    endtask

    task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] exp, input string tag);
        start_op(m, d, a, b, exp, 1'b0);
        wait_rdy(tag, 1, 34);
        @(posedge clock); #1;
    endtask

    initial begin
        logic [31:0] sp [6];
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rm;
        int          seen;

        sp = '{32'd0, 32'd1, 32'hFFFF_FFFF, C_INT_MIN, 32'h7FFF_FFFF, 32'd2};
        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", {1'b0, data_result}, 33'd0);
        check("rst_exc", {32'd0, data_exception}, 33'd0);
        check("rst_rdy", {32'd0, data_resultRDY}, 33'd0);
        check("rst_busy", {32'd0, busy}, 33'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 6 x 7 with latency, busy window and hold checks
        start_op(1'b1, 1'b0, 32'd6, 32'd7, {1'b0, 32'd42}, 1'b0);
        check("busy_c1", {32'd0, busy}, 33'd1);
        wait_rdy("lat_mul", 1, 34);
        check("busy_c34", {32'd0, busy}, 33'd1);
        @(posedge clock); #1;
        check("rdy_c35", {32'd0, data_resultRDY}, 33'd0);
        check("hold_c35", {1'b0, data_result}, {1'b0, 32'd42});
        check("busy_c35", {32'd0, busy}, 33'd0);

        do_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, {1'b0, 32'hFFFF_FFF1}, "lat_mul_neg");
        do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, {1'b1, 32'd0}, "lat_mul_ovf");
        do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFD}, "lat_div_neg_a");
        do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, {1'b0, 32'hFFFF_FFFD}, "lat_div_neg_b");
        do_op(1'b0, 1'b1, 32'd5, 32'd0, {1'b1, 32'd0}, "lat_div_zero");
        do_op(1'b0, 1'b1, C_INT_MIN, 32'hFFFF_FFFF, {1'b1, C_INT_MIN}, "lat_div_ovf");
        do_op(1'b1, 1'b1, 32'd9, 32'd3, {1'b0, 32'd27}, "lat_both");

        // Abort: divide at cycle 0, multiply at cycle 10, single strobe at 44
        start_op(1'b0, 1'b1, 32'd100, 32'd7, {1'b0, 32'd14}, 1'b0);
        repeat (9) begin @(posedge clock); #1; end
        start_op(1'b1, 1'b0, 32'd3, 32'd4, {1'b0, 32'd12}, 1'b1);
        wait_rdy("lat_abort", 1, 34);
        @(posedge clock); #1;

        // Start in the DONE cycle: first strobe survives, second follows 34 later
        start_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, {1'b0, 32'd9}, 1'b0);
        repeat (32) begin @(posedge clock); #1; end
        start_op(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF6, {1'b0, 32'hFFFF_FF9C}, 1'b0);
        check("rdy_done_start", {32'd0, data_resultRDY}, 33'd1);
        @(posedge clock); #1;
        wait_rdy("lat_b2b", 2, 34);
        @(posedge clock); #1;

        // Reset during a divide
        start_op(1'b0, 1'b1, 32'd12345, 32'd67, {1'b0, 32'd184}, 1'b0);
        repeat (19) begin @(posedge clock); #1; end
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_result", {1'b0, data_result}, 33'd0);
        check("mid_rst_exc", {32'd0, data_exception}, 33'd0);
        check("mid_rst_rdy", {32'd0, data_resultRDY}, 33'd0);
        check("mid_rst_busy", {32'd0, busy}, 33'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1) seen++;
        end
        check("no_rdy_after_rst", 33'(seen), 33'd0);

        // Randomized operands, biased toward corner values
        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
            rm = i[0];
            do_op(rm, !rm, ra, rb, model(rm, ra, rb), "lat_rand");
        end

        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", 33'(exp_q.size()), 33'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
